// File: rtl/w0rm_core_regfile_sb.sv
// w0rm_core_regfile_sb: register-fetch stage with busy scoreboard, write-back bypass and flush
module w0rm_core_regfile_sb #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 2,
  parameter int USER_WIDTH = 61,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                           core_clk,
  input  logic                           reset,
  input  logic                           decode_valid,
  output logic                           decode_ready,
  input  logic [NUM_READ-1:0]            rd_en,
  input  logic [NUM_READ*AW-1:0]         rd_addr,
  input  logic                           claim_en,
  input  logic [AW-1:0]                  claim_addr,
  input  logic [USER_WIDTH-1:0]          user_data_in,
  output logic                           rfetch_valid,
  input  logic                           alu_ready,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [USER_WIDTH-1:0]          user_data_out,
  input  logic                           flush,
  input  logic                           wb_enable,
  input  logic [AW-1:0]                  wb_addr,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  output logic [NUM_REGS-1:0]            busy_o
);
  logic [DATA_WIDTH-1:0]          regs [NUM_REGS];
  logic [NUM_REGS-1:0]            busy, busy_nxt;
  logic                           held_en, hazard, accept;
  logic [AW-1:0]                  held_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data_nxt;

  // a busy register stops being a hazard in the cycle its write-back lands
  function automatic logic hit(input logic [AW-1:0] a);
    return busy[a] && !(wb_enable && wb_addr == a);
  endfunction

  always_comb begin
    hazard = claim_en && hit(claim_addr);
    rd_data_nxt = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      hazard = hazard | (rd_en[p] && hit(rd_addr[p*AW +: AW]));
      rd_data_nxt[p*DATA_WIDTH +: DATA_WIDTH] = (wb_enable && wb_addr == rd_addr[p*AW +: AW]) ?
        wb_data : regs[rd_addr[p*AW +: AW]];
    end
  end

  assign decode_ready = !reset && !flush && !hazard && (!rfetch_valid || alu_ready);
  assign accept       = decode_valid && decode_ready;
  assign busy_o       = busy;

  // claim set is applied last so it wins over a same-cycle write-back clear
  always_comb begin
    busy_nxt = busy;
    if (wb_enable) busy_nxt[wb_addr] = 1'b0;
    if (flush && rfetch_valid && held_en) busy_nxt[held_addr] = 1'b0;
    if (accept && claim_en) busy_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy          <= '0;
      rfetch_valid  <= 1'b0;
      rd_data       <= '0;
      user_data_out <= '0;
      held_en       <= 1'b0;
      held_addr     <= '0;
    end else begin
      if (wb_enable) regs[wb_addr] <= wb_data;
      busy         <= busy_nxt;
      rfetch_valid <= flush ? 1'b0 : accept ? 1'b1 : alu_ready ? 1'b0 : rfetch_valid;
      if (accept) begin
        rd_data       <= rd_data_nxt;
        user_data_out <= user_data_in;
        held_en       <= claim_en;
        held_addr     <= claim_addr;
      end
    end
  end
endmodule

// File: doc/w0rm_core_regfile_sb.md
Name: w0rm_core_regfile_sb

Overview:
- Parametrised register-fetch stage for the W0RM pipeline, sitting between Decode and the ALU.
- Holds NUM_REGS x DATA_WIDTH registers with NUM_READ read ports and one write-back port.
- Adds a per-register busy scoreboard for RAW/WAW hazard stalls, write-back bypass and an output flush.
- Carries USER_WIDTH bits of decoded control alongside operands, under a valid/ready handshake.

Parameters:
- NUM_REGS, 16, number of architectural registers (power of two, >=2); localparam AW = clog2(NUM_REGS)
- DATA_WIDTH, 32, register width
- NUM_READ, 2, number of read ports (1..4)
- USER_WIDTH, 61, width of the pass-through control bundle

Ports:
- core_clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- decode_valid  in  1  Decode presents an instruction
- decode_ready  out  1  stage accepts this cycle
- rd_en  in  NUM_READ  per-port read enable (hazard checked only when set)
- rd_addr  in  NUM_READ*AW  packed read addresses, port 0 in LSBs
- claim_en  in  1  instruction will write a register
- claim_addr  in  AW  destination register
- user_data_in  in  USER_WIDTH  decoded control bundle
- rfetch_valid  out  1  output stage holds an instruction
- alu_ready  in  1  ALU consumes the output this cycle
- rd_data  out  NUM_READ*DATA_WIDTH  packed operands
- user_data_out  out  USER_WIDTH  registered control bundle
- flush  in  1  cancel the instruction held in the output stage
- wb_enable  in  1  write-back strobe
- wb_addr  in  AW  write-back register
- wb_data  in  DATA_WIDTH  write-back value
- busy_o  out  NUM_REGS  scoreboard state (debug/verify)

Behaviour:
- Reset, one cycle: all registers 0, busy 0, rfetch_valid 0, rd_data 0, user_data_out 0, held claim cleared. Reset overrides all other inputs, including a reset asserted mid-stall.
- hit(a) = busy[a] && !(wb_enable && wb_addr==a).
- hazard = OR over ports p of (rd_en[p] && hit(rd_addr[p])), OR (claim_en && hit(claim_addr)).
- decode_ready = !reset && !flush && !hazard && (!rfetch_valid || alu_ready). It is combinational and does not depend on decode_valid.
- accept = decode_valid && decode_ready. On accept, at the next edge:
  - rfetch_valid = 1.
  - rd_data[p] = wb_data if wb_enable && wb_addr==rd_addr[p], else regs[rd_addr[p]].
  - user_data_out = user_data_in.
  - held claim = {claim_en, claim_addr}.
- Latency: 1 cycle from accept to rfetch_valid. Back-to-back accepts are allowed at full throughput when alu_ready=1.
- Hold: if rfetch_valid && !alu_ready && !flush, all outputs are stable. Operands are captured at accept and never refreshed afterwards.
- Drain: rfetch_valid && alu_ready && !accept → rfetch_valid = 0. rd_data and user_data_out keep their last values.
- Write-back: wb_enable → regs[wb_addr] = wb_data and busy[wb_addr] cleared. No write-protected register.
- Claim: on accept with claim_en → busy[claim_addr] set. If the same cycle also clears that address via write-back, set wins.
- Flush with rfetch_valid: rfetch_valid = 0 and busy[held claim addr] cleared, if the held claim was valid. Flush blocks accept that cycle. Flush with alu_ready=1 still cancels; the ALU must ignore that cycle. Write-back in the flush cycle is still performed.
- Write-back and a read of the same register with busy=0 in the same cycle: the bypass supplies the new value.
- busy_o = busy register, registered.

Test Plan:
- Reset then issue rd_addr={r2,r1}, regs pre-written r1=0x11, r2=0x22 → after 1 cycle rfetch_valid=1, rd_data={0x22,0x11}, user_data_out matches the input.
- RAW stall: issue A with claim r3, then B reading r3 → decode_ready=0 while busy[3]=1. wb r3=0xDEAD in cycle N → decode_ready=1 in cycle N, B accepted, B rd_data=0xDEAD (bypass), busy[3]=0.
- Downstream stall: alu_ready=0 for 4 cycles with rfetch_valid=1 → rd_data/user_data_out unchanged, decode_ready=0. On alu_ready=1, the next instruction is accepted the same cycle.
- WAW plus simultaneous set/clear: r5 busy, issue claim r5 in the same cycle as wb r5 → accepted, busy[5] remains 1 afterwards.
- Flush: held instruction with claim r7 (busy[7]=1), flush=1 → next cycle rfetch_valid=0, busy[7]=0. decode_ready=0 during the flush cycle.
- Reset mid-stall with busy=0xFFFF and rfetch_valid=1 → next cycle busy_o=0, rfetch_valid=0, all registers read 0.
